// File: rtl/cache_xfer_pkg.sv
// Shared types and sizing helpers for the cache line transfer engine.
package cache_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } xfer_state_e;

  function automatic int beat_idx_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  function automatic int beat_bytes(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int line_bytes(input int block_w);
    return block_w / 8;
  endfunction

endpackage

// File: rtl/cache_line_transfer_engine_beat_counter.sv
// Modulo-BEATS beat counter: load clears, enable advances, o_tc flags the last beat.
module beat_counter
  import cache_xfer_pkg::*;
#(
  parameter int BEATS = 16
) (
  input  logic i_clk,
  input  logic i_arst,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);

  localparam int IW = beat_idx_w(BEATS);

  logic [IW-1:0] count_q;
  logic [IW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = '0;
    end else if (i_en) begin
      count_d = (count_q == IW'(BEATS - 1)) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_tc = (count_q == IW'(BEATS - 1));

endmodule

// File: rtl/cache_line_transfer_engine.sv
// Moves one cache line as a sequence of single-outstanding AXI-side beats (fill or writeback).
// Optional build macro CACHE_XFER_CWF_EN: critical-word-first reads plus o_cwf_valid pulse.
module cache_line_transfer_engine
  import cache_xfer_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int BLOCK_WIDTH    = 512
) (
  input  logic                      i_clk,
  input  logic                      i_arst,
  input  logic                      i_start_read,
  input  logic                      i_start_write,
  input  logic [AXI_ADDR_WIDTH-1:0] i_addr_cache,
  input  logic [BLOCK_WIDTH-1:0]    i_data_block_cache,
  output logic                      o_req_valid,
  input  logic                      i_req_ready,
  output logic                      o_req_we,
  output logic [AXI_ADDR_WIDTH-1:0] o_addr_axi,
  output logic [AXI_DATA_WIDTH-1:0] o_data_axi,
  input  logic                      i_rsp_valid,
  input  logic                      i_rsp_error,
  input  logic [AXI_DATA_WIDTH-1:0] i_data_axi,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_error,
`ifdef CACHE_XFER_CWF_EN
  output logic                      o_cwf_valid,
`endif
  output logic [BLOCK_WIDTH-1:0]    o_data_block_cache
);

  localparam int BEATS      = BLOCK_WIDTH / AXI_DATA_WIDTH;
  localparam int BEAT_BYTES = beat_bytes(AXI_DATA_WIDTH);
  localparam int LINE_BYTES = line_bytes(BLOCK_WIDTH);
  localparam int IW         = beat_idx_w(BEATS);
  localparam int BB_LOG     = $clog2(BEAT_BYTES);
  localparam logic [AXI_ADDR_WIDTH-1:0] LINE_MASK = AXI_ADDR_WIDTH'(LINE_BYTES - 1);

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == IW'(BEATS - 1)) ? '0 : idx + 1'b1;
  endfunction

  function automatic logic [AXI_ADDR_WIDTH-1:0] beat_addr(input logic [AXI_ADDR_WIDTH-1:0] base,
                                                          input logic [IW-1:0] idx);
    return base + (AXI_ADDR_WIDTH'(idx) << BB_LOG);
  endfunction

  function automatic logic [AXI_DATA_WIDTH-1:0] beat_slice(input logic [BLOCK_WIDTH-1:0] line,
                                                           input logic [IW-1:0] idx);
    return line[int'(idx)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
  endfunction

  xfer_state_e               state_q, state_d;
  logic                      we_q, we_d;
  logic [AXI_ADDR_WIDTH-1:0] base_q, base_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [BLOCK_WIDTH-1:0]    line_q, line_d;
  logic [BLOCK_WIDTH-1:0]    buf_q, buf_d;
  logic [BLOCK_WIDTH-1:0]    out_q, out_d;
  logic                      req_valid_q, req_valid_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] data_q, data_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      error_q, error_d;
`ifdef CACHE_XFER_CWF_EN
  logic                      first_q, first_d;
  logic                      cwf_valid_q, cwf_valid_d;
`endif

  logic          cnt_load;
  logic          cnt_en;
  logic          cnt_tc;
  logic          rsp_err;
  logic [IW-1:0] start_idx;

  beat_counter #(
    .BEATS (BEATS)
  ) u_beat_counter (
    .i_clk  (i_clk),
    .i_arst (i_arst),
    .i_load (cnt_load),
    .i_en   (cnt_en),
    .o_tc   (cnt_tc)
  );

  assign rsp_err = i_rsp_valid & i_rsp_error;

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    base_d      = base_q;
    idx_d       = idx_q;
    line_d      = line_q;
    buf_d       = buf_q;
    out_d       = out_q;
    req_valid_d = req_valid_q;
    addr_d      = addr_q;
    data_d      = data_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    cnt_load    = 1'b0;
    cnt_en      = 1'b0;
    start_idx   = '0;
`ifdef CACHE_XFER_CWF_EN
    first_d     = first_q;
    cwf_valid_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        // Write takes priority when both starts arrive together; the read is dropped.
        if (i_start_read || i_start_write) begin
`ifdef CACHE_XFER_CWF_EN
          start_idx = i_start_write ? '0 : IW'(i_addr_cache[$clog2(LINE_BYTES)-1:BB_LOG]);
          first_d   = 1'b1;
`endif
          state_d     = REQ;
          we_d        = i_start_write;
          base_d      = i_addr_cache & ~LINE_MASK;
          idx_d       = start_idx;
          line_d      = i_data_block_cache;
          cnt_load    = 1'b1;
          req_valid_d = 1'b1;
          addr_d      = beat_addr(base_d, start_idx);
          data_d      = beat_slice(i_data_block_cache, start_idx);
        end
      end
      REQ: begin
        if (i_req_ready) begin
          state_d     = WAIT;
          req_valid_d = 1'b0;
        end
      end
      WAIT: begin
        if (i_rsp_valid) begin
          cnt_en = 1'b1;
          if (!we_q && !rsp_err) begin
            buf_d[int'(idx_q)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = i_data_axi;
          end
`ifdef CACHE_XFER_CWF_EN
          cwf_valid_d = first_q && !we_q && !rsp_err;
          first_d     = 1'b0;
`endif
          if (rsp_err || cnt_tc) begin
            state_d = DONE;
            done_d  = 1'b1;
            error_d = rsp_err;
            if (!we_q && !rsp_err) begin
              out_d = buf_d;
            end
          end else begin
            state_d     = REQ;
            idx_d       = next_idx(idx_q);
            req_valid_d = 1'b1;
            addr_d      = beat_addr(base_q, idx_d);
            data_d      = beat_slice(line_q, idx_d);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      base_q      <= '0;
      idx_q       <= '0;
      line_q      <= '0;
      buf_q       <= '0;
      out_q       <= '0;
      req_valid_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef CACHE_XFER_CWF_EN
      first_q     <= 1'b0;
      cwf_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      base_q      <= base_d;
      idx_q       <= idx_d;
      line_q      <= line_d;
      buf_q       <= buf_d;
      out_q       <= out_d;
      req_valid_q <= req_valid_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef CACHE_XFER_CWF_EN
      first_q     <= first_d;
      cwf_valid_q <= cwf_valid_d;
`endif
    end
  end

  assign o_req_valid        = req_valid_q;
  assign o_req_we           = we_q;
  assign o_addr_axi         = addr_q;
  assign o_data_axi         = data_q;
  assign o_busy             = busy_q;
  assign o_done             = done_q;
  assign o_error            = error_q;
  assign o_data_block_cache = out_q;
`ifdef CACHE_XFER_CWF_EN
  assign o_cwf_valid        = cwf_valid_q;
`endif

endmodule

// File: doc/cache_line_transfer_engine.md
Name: cache_line_transfer_engine

Overview:
Moves one cache line between the cache and the AXI-side beat interface, as a line-fill read or a writeback write. Parametrised successor to the fixed 32-bit line mover: generic beat width and line size, valid/ready request handshake, per-beat response with error, and random-access beat placement instead of shifting. Sits between the cache controller FSM and the AXI master adapter.

Parameters:
AXI_DATA_WIDTH, 32, beat data width in bits; power of two, ≥8.
AXI_ADDR_WIDTH, 64, address width.
BLOCK_WIDTH, 512, cache line width in bits; integer multiple of AXI_DATA_WIDTH.
Derived localparams: BEATS = BLOCK_WIDTH/AXI_DATA_WIDTH (≥2); BEAT_BYTES = AXI_DATA_WIDTH/8; LINE_BYTES = BLOCK_WIDTH/8.

Ports:
i_clk  in  1  clock.
i_arst  in  1  reset: one clock, synchronous, active-high.
i_start_read  in  1  pulse: start line fill.
i_start_write  in  1  pulse: start writeback.
i_addr_cache  in  AXI_ADDR_WIDTH  line address, sampled at start.
i_data_block_cache  in  BLOCK_WIDTH  writeback line, sampled at start.
o_req_valid  out  1  beat request valid.
i_req_ready  in  1  adapter accepts request.
o_req_we  out  1  1 = write beat.
o_addr_axi  out  AXI_ADDR_WIDTH  beat address.
o_data_axi  out  AXI_DATA_WIDTH  write beat data.
i_rsp_valid  in  1  beat response (read data or write ack).
i_rsp_error  in  1  beat error, qualified by i_rsp_valid.
i_data_axi  in  AXI_DATA_WIDTH  read beat data.
o_busy  out  1  transfer in progress.
o_done  out  1  one-cycle completion pulse.
o_error  out  1  transfer aborted; valid with o_done.
o_data_block_cache  out  BLOCK_WIDTH  filled line.

Behaviour:
- Reset: all outputs 0, FSM IDLE, counter 0, line buffer cleared. Reset mid-transfer abandons it; no o_done.
- FSM: IDLE -> REQ on accepted start; REQ -> WAIT when o_req_valid & i_req_ready; WAIT -> REQ on i_rsp_valid with beats remaining; WAIT -> DONE on last beat response or any i_rsp_error; DONE -> IDLE after one cycle (o_done=1).
- Start in IDLE only; starts while busy ignored. Both starts same cycle: write wins, read dropped (controller reissues).
- Base = i_addr_cache with low log2(LINE_BYTES) bits cleared. Beat k address = base + k*BEAT_BYTES; beat index width clog2(BEATS), wraps modulo BEATS.
- One outstanding beat. o_req_valid, o_addr_axi, o_req_we, o_data_axi held stable until i_req_ready; i_rsp_valid ignored outside WAIT.
- Write: o_data_axi = latched line slice [k*W +: W]. Read: i_data_axi stored into slot k of buffer.
- o_busy = 1 from cycle after accepted start through DONE.
- o_data_block_cache updated only on read completion without error; held until next successful read. Error leaves previous line contents; o_error=1 with o_done, cleared next cycle.
- Latency, zero-wait adapter: start -> o_done = 2*BEATS+1 cycles.

Optional Feature:
CACHE_XFER_CWF_EN: reads are critical-word-first; first beat index = i_addr_cache[log2(LINE_BYTES)-1 : log2(BEAT_BYTES)], wrapping modulo BEATS, data placed by true index. Extra output o_cwf_valid pulses with the first read beat for early restart. Writes stay aligned from beat 0. Without macro: all transfers start at beat 0; no o_cwf_valid port.

Decomposition:
- Package cache_xfer_pkg: state enum (IDLE, REQ, WAIT, DONE), beat-index width function, BEAT_BYTES/LINE_BYTES helpers.
- Sub-module beat_counter: parametrised modulo-BEATS counter with load, enable, terminal-count flag.

Test Plan (512/32, BEATS=16):
- Read at 0x1000, adapter ready, data = beat index -> 16 requests 0x1000..0x103C, o_done at cycle 33, line word k = k.
- Write at 0x2040, line word k = 0xA000+k -> addresses 0x2040..0x207C, o_data_axi = 0xA000..0xA00F in order, o_req_we=1.
- i_req_ready low 3 cycles on beat 5 -> request signals stable throughout; done delayed 3 cycles.
- i_rsp_error on beat 7 of read -> o_done+o_error same cycle, o_data_block_cache unchanged.
- Both starts same cycle, then start during busy -> only write runs; second start ignored.
- CWF build, read at 0x1024 -> beat order 9..15,0..8, o_cwf_valid with first beat; reset at beat 4 -> outputs 0, no o_done.
